change_dispenser: RTL and testbench

//   Return path of the vending machine: pays coins back out to the customer.

---
 rtl/change_dispenser.sv | 156 +++++++++++++++
 tb/tb_change_dispenser.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Refund path of the vending machine: pays a refund back as 10- and 5-coins,
// greedily from its own inventory, one coin per hopper handshake.
module change_dispenser #(
   parameter int unsigned AMT_W      = 4,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned INIT_FIVES = 8,
   parameter int unsigned INIT_TENS  = 8,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AMT_W-1:0] req_amount,
   output logic [1:0]       coin,
   output logic             coin_valid,
   input  logic             coin_ack,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] short_amount,
   output logic [CNT_W-1:0] fives_cnt,
   output logic [CNT_W-1:0] tens_cnt,
   input  logic             restock_valid,
   input  logic [CNT_W-1:0] restock_fives,
   input  logic [CNT_W-1:0] restock_tens
);

   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);
   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_ISSUE, S_GAP, S_DONE, S_SHORT
   } state_t;

   state_t state, next_state;

   logic [AMT_W-1:0] remaining;
   logic [GAP_W-1:0] gap_cnt;
   logic             accept;
   logic             restock_en;
   logic             pay;
   logic             pick_ten;
   logic             pick_five;

   logic             req_ready_d;
   logic [1:0]       coin_d;
   logic             coin_valid_d;
   logic             done_d;
   logic             short_d;
   logic [AMT_W-1:0] short_amount_d;

   assign accept     = req_valid && req_ready;
   assign restock_en = restock_valid && (state == S_IDLE);
   assign pay        = (state == S_ISSUE) && coin_ack;
   assign pick_ten   = (remaining >= AMT_W'(2)) && (tens_cnt != '0);
   assign pick_five  = (remaining != '0) && (fives_cnt != '0);

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (accept) next_state = S_SELECT;
         S_SELECT: begin
            if (remaining == '0)          next_state = S_DONE;
            else if (pick_ten || pick_five) next_state = S_ISSUE;
            else                          next_state = S_SHORT;
         end
         S_ISSUE:  if (coin_ack) next_state = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
         S_GAP:    if (gap_cnt <= GAP_W'(1)) next_state = S_SELECT;
         S_DONE:   next_state = S_IDLE;
         S_SHORT:  next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Output values for the coming cycle, decoded from the next state
   always_comb begin
      req_ready_d    = (next_state == S_IDLE);
      coin_valid_d   = (next_state == S_ISSUE);
      done_d         = (next_state == S_DONE);
      short_d        = (next_state == S_SHORT);
      coin_d         = COIN_NONE;
      short_amount_d = short_amount;
      if (next_state == S_ISSUE)
         coin_d = (state == S_SELECT) ? (pick_ten ? COIN_10 : COIN_5) : coin;
      if (accept)
         short_amount_d = '0;
      if (next_state == S_SHORT)
         short_amount_d = remaining;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         req_ready    <= 1'b1;
         coin         <= COIN_NONE;
         coin_valid   <= 1'b0;
         done         <= 1'b0;
         short        <= 1'b0;
         short_amount <= '0;
      end else begin
         req_ready    <= req_ready_d;
         coin         <= coin_d;
         coin_valid   <= coin_valid_d;
         done         <= done_d;
         short        <= short_d;
         short_amount <= short_amount_d;
      end
   end

   // Refund remainder and inter-coin gap counter
   always_ff @(posedge clock) begin
      if (reset) begin
         remaining <= '0;
         gap_cnt   <= '0;
      end else begin
         if (accept)
            remaining <= req_amount;
         else if (pay)
            remaining <= remaining - ((coin == COIN_10) ? AMT_W'(2) : AMT_W'(1));
         if (pay)
            gap_cnt <= GAP_W'(GAP_CYCLES);
         else if ((state == S_GAP) && (gap_cnt != '0))
            gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   // Inventory: restock only while idle, decrement once per acknowledged coin
   always_ff @(posedge clock) begin
      if (reset) begin
         fives_cnt <= CNT_W'(INIT_FIVES);
         tens_cnt  <= CNT_W'(INIT_TENS);
      end else if (restock_en) begin
         fives_cnt <= sat_add(fives_cnt, restock_fives);
         tens_cnt  <= sat_add(tens_cnt, restock_tens);
      end else if (pay) begin
         if (coin == COIN_10) tens_cnt  <= tens_cnt - CNT_W'(1);
         else                 fives_cnt <= fives_cnt - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed and randomized refunds checked against
// a greedy arithmetic model of the inventory and payout.
module tb_change_dispenser;

   localparam int GAP = 2;
   localparam int MAXC = 255;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_amount;
   logic [1:0] coin;
   logic       coin_valid;
   logic       coin_ack;
   logic       done;
   logic       short;
   logic [3:0] short_amount;
   logic [7:0] fives_cnt;
   logic [7:0] tens_cnt;
   logic       restock_valid;
   logic [7:0] restock_fives;
   logic [7:0] restock_tens;

   int n_pass  = 0;
   int n_total = 0;
   int m_f, m_t;

   change_dispenser #(
      .AMT_W(4), .CNT_W(8), .INIT_FIVES(8), .INIT_TENS(8), .GAP_CYCLES(GAP)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_amount(req_amount),
      .coin(coin), .coin_valid(coin_valid), .coin_ack(coin_ack),
      .done(done), .short(short), .short_amount(short_amount),
      .fives_cnt(fives_cnt), .tens_cnt(tens_cnt),
      .restock_valid(restock_valid), .restock_fives(restock_fives),
      .restock_tens(restock_tens)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_counts(input string tag);
      chk(tag, {16'h0, fives_cnt, tens_cnt}, {16'h0, 8'(m_f), 8'(m_t)});
   endtask

   // One refund: model decides the coin list, bench plays hopper and checks
   task automatic do_refund(input int amt, input int min_lat, input int max_lat,
                            input bit rs, input int rf, input int rt);
      int n10, n5, rem, w, lat;
      bit hold;
      logic [1:0] exp_coin;
      hold = 1'b0;
      w = 0;
      while (!req_ready && w < 50) begin step(); w++; end
      chk("ready_before", req_ready, 1);
      if (rs) begin
         m_f = (m_f + rf > MAXC) ? MAXC : m_f + rf;
         m_t = (m_t + rt > MAXC) ? MAXC : m_t + rt;
      end
      rem = amt;
      n10 = (rem / 2 < m_t) ? rem / 2 : m_t;
      rem = rem - 2 * n10;
      n5  = (rem < m_f) ? rem : m_f;
      rem = rem - n5;

      req_valid = 1'b1; req_amount = 4'(amt);
      restock_valid = rs; restock_fives = 8'(rf); restock_tens = 8'(rt);
      step();
      req_valid = 1'b0; restock_valid = 1'b0;
      chk("select_cycle", {req_ready, coin_valid, done, short}, 4'b0000);
      chk_counts("restock_counts");

      for (int k = 0; k < n10 + n5; k++) begin
         exp_coin = (k < n10) ? 2'b10 : 2'b01;
         w = 0;
         while (!coin_valid && w < 20) begin
            coin_ack = hold && (w == 0);
            step();
            w++;
         end
         coin_ack = 1'b0;
         chk("coin_latency", w, (k == 0) ? 1 : GAP + 1);
         chk("coin_value", {coin_valid, coin}, {1'b1, exp_coin});
         lat = $urandom_range(max_lat, min_lat);
         for (int j = 0; j < lat; j++) begin
            req_valid     = 1'($urandom_range(1, 0));
            req_amount    = 4'($urandom_range(15, 0));
            restock_valid = 1'($urandom_range(1, 0));
            restock_fives = 8'($urandom_range(9, 1));
            restock_tens  = 8'($urandom_range(9, 1));
            step();
            chk("coin_hold", {coin_valid, req_ready, coin}, {1'b1, 1'b0, exp_coin});
            chk_counts("counts_while_held");
         end
         req_valid = 1'b0; restock_valid = 1'b0;
         coin_ack = 1'b1;
         step();
         hold = 1'($urandom_range(1, 0));
         coin_ack = hold;
         if (k < n10) m_t--; else m_f--;
         chk("coin_dropped", {coin_valid, coin}, 3'b000);
         chk_counts("counts_after_ack");
      end

      w = 0;
      while (!(done || short) && w < 20) begin
         coin_ack = hold && (w == 0);
         step();
         w++;
         if (coin_valid) chk("unexpected_coin", coin_valid, 0);
      end
      coin_ack = 1'b0;
      chk("end_latency", w, (n10 + n5 == 0) ? 1 : GAP + 1);
      chk("end_kind", {done, short}, (rem == 0) ? 2'b10 : 2'b01);
      chk("short_amount", short_amount, rem);
      step();
      chk("end_pulse_1cyc", {done, short, req_ready}, 3'b001);
      chk("short_amount_held", short_amount, rem);
      chk_counts("counts_final");
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_amount = '0; coin_ack = 1'b0;
      restock_valid = 1'b0; restock_fives = '0; restock_tens = '0;
      step();
      step();
      chk("reset_outputs", {req_ready, coin, coin_valid, done, short, short_amount},
          {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0});
      chk("reset_counts", {fives_cnt, tens_cnt}, {8'd8, 8'd8});
      reset = 1'b0;
      m_f = 8; m_t = 8;

      // Coins 10,10,5 from a fresh inventory
      do_refund(5, 0, 3, 1'b0, 0, 0);
      // Drain tens, then fives, then run short
      do_refund(15, 0, 2, 1'b0, 0, 0);
      do_refund(15, 0, 1, 1'b0, 0, 0);
      do_refund(3, 0, 0, 1'b0, 0, 0);
      // Restock one ten in the accept cycle: one coin 10 then short of 1
      do_refund(3, 0, 2, 1'b1, 0, 1);
      // Only fives available: 5,5,5
      do_refund(3, 0, 2, 1'b1, 3, 0);
      // Zero refund, with tens restock saturating
      do_refund(0, 0, 0, 1'b1, 0, 255);
      do_refund(0, 0, 0, 1'b1, 250, 255);
      // Long ack delay with requests poking at the closed port
      do_refund(4, 6, 6, 1'b0, 0, 0);

      // Reset while a coin is offered
      w_reset_test();

      for (int i = 0; i < 25; i++) begin
         int rf, rt;
         rf = ($urandom_range(3, 0) == 0) ? $urandom_range(255, 200) : $urandom_range(6, 0);
         rt = ($urandom_range(3, 0) == 0) ? $urandom_range(255, 200) : $urandom_range(4, 0);
         do_refund($urandom_range(15, 0), 0, 4, 1'($urandom_range(2, 0) == 0), rf, rt);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   task automatic w_reset_test();
      int w;
      w = 0;
      while (!req_ready && w < 50) begin step(); w++; end
      req_valid = 1'b1; req_amount = 4'd5;
      step();
      req_valid = 1'b0;
      step();
      chk("pre_reset_coin", coin_valid, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_f = 8; m_t = 8;
      chk("reset_mid_outputs", {coin_valid, coin, req_ready, done, short}, {1'b0, 2'b00, 1'b1, 1'b0, 1'b0});
      chk_counts("reset_mid_counts");
      coin_ack = 1'b1;
      step();
      coin_ack = 1'b0;
      step();
      chk("late_ack_ignored", {coin_valid, req_ready}, 2'b01);
      chk_counts("late_ack_counts");
   endtask

endmodule
